// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional baud-rate generator producing oversample, mid-bit
// and bit ticks from one system clock.
// Build option: define BAUD_GEN_FRAC_EN to include the fractional accumulator.
// Without it, div_frac is ignored and the block is a pure integer divider.
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR/2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

  logic [DIV_W-1:0] div_int_q;
  logic [DIV_W:0]   eff;          // active integer divisor, 0 promoted to 1
  logic [DIV_W:0]   eff_in;       // same promotion applied to the load value
  logic [DIV_W:0]   period;       // length of the interval currently counting
  logic [DIV_W:0]   cyc_cnt;
  logic [DIV_W:0]   next_period;  // length of the interval after this os_tick
  logic [OS_W-1:0]  os_cnt;
  logic             wrap;

  assign eff    = (div_int_q == '0) ? CNT_ONE : {1'b0, div_int_q};
  assign eff_in = (div_int == '0)   ? CNT_ONE : {1'b0, div_int};
  assign wrap   = (cyc_cnt == period - CNT_ONE);

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  // Fractional phase: the carry out of the accumulator stretches the next interval by one cycle
  assign sum         = {1'b0, acc} + {1'b0, div_frac_q};
  assign next_period = eff + (DIV_W+1)'(sum[FRAC_W]);

  // Accumulator and fractional divisor; cleared on every phase reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_frac_q <= '0;
      acc        <= '0;
    end else if (load) begin
      div_frac_q <= div_frac;
      acc        <= '0;
    end else if (resync) begin
      acc <= '0;
    end else if (en && wrap) begin
      acc <= sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_div_frac;

  // Integer-only build: every interval is exactly eff cycles
  assign next_period     = eff;
  assign unused_div_frac = ^div_frac;
`endif

  // Cycle and oversample counters with registered tick outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div_int_q <= DIV_W'(1);
      period    <= CNT_ONE;
      cyc_cnt   <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      bit_tick  <= 1'b0;
    end else if (load) begin
      div_int_q <= div_int;
      period    <= eff_in;
      cyc_cnt   <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      bit_tick  <= 1'b0;
    end else if (resync) begin
      period    <= eff;
      cyc_cnt   <= '0;
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      bit_tick  <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cyc_cnt  <= '0;
        period   <= next_period;
        os_tick  <= 1'b1;
        mid_tick <= (os_cnt == OS_MID);
        bit_tick <= (os_cnt == OS_LAST);
        os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
      end else begin
        cyc_cnt  <= cyc_cnt + CNT_ONE;
        os_tick  <= 1'b0;
        mid_tick <= 1'b0;
        bit_tick <= 1'b0;
      end
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Parametrised fractional baud-rate generator, successor to the fixed 8-bit integer divider. Produces an oversample tick, a mid-bit sample tick and a bit tick from one system clock. The divisor is runtime-programmable with an integer and a fractional part. Feeds the UART TX serializer (bit_tick) and the RX sampler (os_tick, mid_tick). A resync input phase-aligns the generator to a detected start-bit edge.

Parameters:
DIV_W, 16, width of integer divisor part (cycles per oversample interval)
FRAC_W, 4, width of fractional divisor part; resolution 1/2^FRAC_W cycle
OSR, 16, oversample intervals per bit; even, >= 4

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  count enable; hold state when low
load  input  1  one-cycle strobe: capture div_int/div_frac into active registers
div_int  input  DIV_W  integer cycles per oversample interval; 0 treated as 1
div_frac  input  FRAC_W  fractional cycles per interval, in units of 2^-FRAC_W
resync  input  1  one-cycle strobe: clear phase (counters, accumulator)
os_tick  output  1  one-cycle pulse per oversample interval
mid_tick  output  1  one-cycle pulse at the middle of each bit (OSR/2-th os_tick)
bit_tick  output  1  one-cycle pulse per bit (every OSR-th os_tick)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high on rst.
- Reset: active div_int_q=1, div_frac_q=0, cyc_cnt=0, os_cnt=0, acc=0, period=div_int_q. All outputs 0 in the cycle after rst is sampled high.
- All outputs are registered. Each is high for exactly one cycle.
- Effective integer: eff = (div_int_q==0) ? 1 : div_int_q.
- Interval length: period = eff + c, held in DIV_W+1 bits. c is the carry from the previous os_tick's accumulator add; c=0 for the first interval after reset, resync or load.
- Counting: on an enabled cycle, if cyc_cnt == period-1 then cyc_cnt<=0 and os_tick<=1. Otherwise cyc_cnt increments and os_tick<=0.
- With en held high from the first post-reset edge, os_tick is first visible after period edges.
- At each os_tick, the FRAC_W-bit accumulator updates {c, acc} <= acc + div_frac_q. Overflow wraps. The carry sets the next period to eff+1.
- Long-run average interval = eff + div_frac_q/2^FRAC_W cycles.
- os_cnt counts os_ticks modulo OSR.
  - mid_tick<=1 together with the os_tick that moves os_cnt from OSR/2-1 to OSR/2.
  - bit_tick<=1 together with the os_tick that wraps os_cnt from OSR-1 to 0.
- en low: all counters, accumulator and period hold. All ticks driven 0. Resuming continues the same phase.
- resync (and not rst): cyc_cnt, os_cnt, acc, c cleared; ticks 0 that cycle. Honoured regardless of en.
- load (and not rst): active divisor updated; same phase clear as resync; ticks 0 that cycle. Takes effect from the next cycle. Honoured regardless of en.
- Priority: rst > load > resync > counting. load and resync together behave as load.
- A divisor change without load has no effect. Inputs are only sampled on load.
- No combinational path from any input to any output.

Optional Feature:
- Macro: BAUD_GEN_FRAC_EN.
- Defined: fractional accumulator present; behaviour as above.
- Undefined: accumulator and carry logic not built. div_frac is ignored (port kept, unconnected). period = eff always, giving a pure integer divider.

Test Plan:
1. rst high 3 cycles, then en=1, load div_int=4, div_frac=0 -> os_tick every 4 cycles from 4 cycles after load; mid_tick at the 8th os_tick (cycle 32); bit_tick at the 16th (cycle 64), then every 64 cycles.
2. BAUD_GEN_FRAC_EN defined, load div_int=4, div_frac=8 -> interval sequence 4,4,5,4,5,...; first bit_tick 71 cycles after load; every subsequent 32 intervals span exactly 144 cycles. Without macro: bit_tick every 64 cycles.
3. load div_int=0 -> os_tick every cycle; bit_tick every 16 cycles; div_int=1 gives an identical trace.
4. Pulse en low for 5 cycles mid-interval -> no ticks while low; tick timeline shifted by exactly 5 cycles; no lost or extra tick.
5. resync 2 cycles before an expected bit_tick -> that bit_tick suppressed; next mid_tick exactly 8*period cycles after resync; next bit_tick exactly 16*period cycles after resync.
6. rst asserted mid-count, and load+resync asserted together -> after rst, outputs 0 and divisor back to 1; load+resync applies the new divisor with a single phase clear.
